// File: rtl/apb_reg_slave.sv
// -----------------------------------------------------------------------------
// apb_reg_slave
//
// APB4 completer with a bank of DEPTH read/write 8-bit registers at addresses
// 0..DEPTH-1. It also has a read-only 8-bit transfer counter at CNT_ADDR. The
// counter counts every completion that does not raise an error. It wraps at
// 8'hFF.
//
// Optional feature macro: APB_REG_WAIT_EN
//   defined     : each access phase is stretched by WAIT_CYCLES wait states.
//   not defined : the wait counter is removed, and every access completes in
//                 its first access cycle.
//
// Ports
//   pclk     in  1 : bus clock. All state updates on its rising edge.
//   presetn  in  1 : asynchronous active-low reset.
//   psel     in  1 : slave select.
//   penable  in  1 : access phase strobe.
//   paddr    in  8 : byte address, captured in the setup phase.
//   pwrite   in  1 : 1 = write, 0 = read, captured in the setup phase.
//   pwdata   in  8 : write data, sampled on the completing edge.
//   prdata   out 8 : read data. It is 0 unless a read completes this cycle.
//   pready   out 1 : combinational. It is high in the final access cycle.
//   pslverr  out 1 : error response. It is high only together with pready.
// -----------------------------------------------------------------------------
module apb_reg_slave #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [7:0]  CNT_ADDR    = 8'hF0
) (
   input  logic       pclk,
   input  logic       presetn,
   input  logic       psel,
   input  logic       penable,
   input  logic [7:0] paddr,
   input  logic       pwrite,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] addr_q, addr_d;
   logic       write_q, write_d;
   logic [7:0] regs_q [DEPTH];
   logic [7:0] regs_d [DEPTH];
   logic [7:0] xfer_cnt_q, xfer_cnt_d;
   logic [3:0] wcnt;

`ifdef APB_REG_WAIT_EN
   logic [3:0] wcnt_q, wcnt_d;
   assign wcnt = wcnt_q;
`else
   assign wcnt = '0;
`endif

   logic       setup;
   logic       access;
   logic       complete;
   logic       addr_is_reg;
   logic       addr_is_cnt;
   logic       err;
   logic [7:0] rd_sel;

   // Bus phase decode. A setup phase is recognised in either state. In ACCESS
   // this makes a new setup without a completion restart the transfer.
   always_comb begin
      setup    = psel & ~penable;
      access   = (state_q == ACCESS) & psel & penable;
      complete = access & (wcnt == '0);
   end

   // Address decode on the captured address. Matching in a loop keeps the
   // array index in range for any 8-bit address.
   always_comb begin
      addr_is_reg = 1'b0;
      rd_sel      = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (addr_q == 8'(i)) begin
            addr_is_reg = 1'b1;
            rd_sel      = regs_q[i];
         end
      end
      addr_is_cnt = (addr_q == CNT_ADDR);
      // The counter is legal only for reads. Unmapped addresses always error.
      err = ~addr_is_reg & ~(addr_is_cnt & ~write_q);
   end

   // Response outputs. These are combinational from state, counter and inputs.
   always_comb begin
      pready  = complete;
      pslverr = complete & err;
      prdata  = '0;
      if (complete && !write_q && !err) begin
         prdata = addr_is_reg ? rd_sel : xfer_cnt_q;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      write_d    = write_q;
      xfer_cnt_d = xfer_cnt_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
      end

      if (setup) begin
         state_d = ACCESS;
         addr_d  = paddr;
         write_d = pwrite;
      end else if (state_q == ACCESS && (!psel || complete)) begin
         state_d = IDLE;
      end

      if (complete && write_q) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (addr_q == 8'(i)) begin
               regs_d[i] = pwdata;
            end
         end
      end

      if (complete && !err) begin
         xfer_cnt_d = xfer_cnt_q + 8'd1;
      end
   end

`ifdef APB_REG_WAIT_EN
   always_comb begin
      wcnt_d = wcnt_q;
      if (setup) begin
         wcnt_d = 4'(WAIT_CYCLES);
      end else if (access && wcnt_q != '0) begin
         wcnt_d = wcnt_q - 4'd1;
      end
   end
`endif

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         write_q    <= 1'b0;
         xfer_cnt_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
`ifdef APB_REG_WAIT_EN
         wcnt_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         xfer_cnt_q <= xfer_cnt_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
`ifdef APB_REG_WAIT_EN
         wcnt_q     <= wcnt_d;
`endif
      end
   end

endmodule
